// File: rtl/uart_alu_if.sv
// Byte-stream handshake between the UART engines and the ALU packet FSM.
// The master drives data/valid and the slave answers with ready.
interface uart_alu_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/uart_alu_top.sv
// Packet-based 32-bit ALU behind an 8N1 UART link.
// Host sends opcode/len header plus operands; 4-byte result is returned.
module uart_rx #(
  parameter int DW      = 8,
  parameter int BIT_CYC = 288
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  uart_alu_if.master m_axis,
  output logic frame_error
);
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [7:0]    sh;

  assign rx_s = sync[1];

  // Start-bit hunt, mid-bit sampling, stop check; a bad stop waits for idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= 2'b11;
      busy          <= 1'b0;
      cnt           <= '0;
      bitn          <= '0;
      sh            <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      frame_error   <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      if (m_axis.tready) m_axis.tvalid <= 1'b0;
      if (!busy) begin
        if (!rx_s) begin
          busy <= 1'b1;
          cnt  <= HALF;
          bitn <= '0;
        end
      end else if (bitn == 4'(DW + 2)) begin
        if (rx_s) busy <= 1'b0;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (bitn == '0) begin
        if (rx_s) begin
          busy <= 1'b0;
        end else begin
          cnt  <= FULL;
          bitn <= 4'd1;
        end
      end else if (bitn <= 4'(DW)) begin
        sh   <= {rx_s, sh[7:1]};
        cnt  <= FULL;
        bitn <= bitn + 1'b1;
      end else begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= sh;
        frame_error   <= !rx_s;
        if (rx_s) busy <= 1'b0;
        else      bitn <= 4'(DW + 2);
      end
    end
  end
endmodule

module uart_tx #(
  parameter int DW      = 8,
  parameter int BIT_CYC = 288
) (
  input  logic clk,
  input  logic rst,
  uart_alu_if.slave s_axis,
  output logic txd
);
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [8:0]    sh;

  assign s_axis.tready = !busy;

  // Start bit, LSB-first data, stop bit; ready again once stop completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      txd  <= 1'b1;
      cnt  <= '0;
      bitn <= '0;
      sh   <= '1;
    end else if (!busy) begin
      if (s_axis.tvalid) begin
        busy <= 1'b1;
        txd  <= 1'b0;
        sh   <= {1'b1, s_axis.tdata};
        cnt  <= FULL;
        bitn <= '0;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (bitn == 4'(DW + 1)) begin
      busy <= 1'b0;
    end else begin
      txd  <= sh[0];
      sh   <= {1'b1, sh[8:1]};
      cnt  <= FULL;
      bitn <= bitn + 1'b1;
    end
  end
endmodule

module uart_alu_top #(
  parameter int datawidth_p = 8,
  parameter int CLK_FREQ_HZ = 33178000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic tx_o
);
  localparam int PRESCALE = CLK_FREQ_HZ / (BAUD_RATE * 8);
  localparam int BIT_CYC  = PRESCALE * 8;
  localparam logic [7:0] OP_ADD = 8'h10;
  localparam logic [7:0] OP_MUL = 8'h11;
  localparam logic [7:0] OP_DIV = 8'h12;

  typedef enum logic [2:0] {
    HDR0, HDR1, LENL, LENH, PAY, EXEC, RESP
  } state_t;

  state_t state, state_n;

  logic rst;
  logic frame_err;
  logic rx_ok;
  logic [7:0] rx_b;

  uart_alu_if rx_bus ();
  uart_alu_if tx_bus ();

  assign rst = !rst_i;
  assign rx_bus.tready = 1'b1;
  assign rx_b  = rx_bus.tdata;
  assign rx_ok = rx_bus.tvalid && !frame_err;

  uart_rx #(.DW(datawidth_p), .BIT_CYC(BIT_CYC)) u_rx (
    .clk         (clk_i),
    .rst         (rst),
    .rxd         (rx_i),
    .m_axis      (rx_bus),
    .frame_error (frame_err)
  );

  uart_tx #(.DW(datawidth_p), .BIT_CYC(BIT_CYC)) u_tx (
    .clk    (clk_i),
    .rst    (rst),
    .s_axis (tx_bus),
    .txd    (tx_o)
  );

  logic [7:0]  op;
  logic [7:0]  len_lo;
  logic [15:0] plen;
  logic [15:0] cnt;
  logic [31:0] word;
  logic [31:0] acc;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  nwords;
  logic [4:0]  div_cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] result;
  logic [1:0]  idx;

  logic        is_add, is_mul, is_div;
  logic [15:0] len_full;
  logic [15:0] cnt_n;
  logic [31:0] word_n;
  logic [31:0] rsh;
  logic [31:0] src_q, src_r;
  logic [32:0] rem_sh;
  logic        ge;
  logic [32:0] rem_d;
  logic [31:0] rem_n, quo_n;

  assign is_add   = (op == OP_ADD);
  assign is_mul   = (op == OP_MUL);
  assign is_div   = (op == OP_DIV);
  assign len_full = {rx_b, len_lo};
  assign cnt_n    = cnt + 16'd1;
  assign word_n   = {word[23:0], rx_b};
  assign rsh      = result << {idx, 3'b000};

  // One restoring-division step; step 0 starts from the raw dividend.
  always_comb begin
    src_q  = (div_cnt == 5'd0) ? dividend : quo;
    src_r  = (div_cnt == 5'd0) ? 32'd0 : rem;
    rem_sh = {src_r, src_q[31]};
    ge     = (rem_sh >= {1'b0, divisor});
    rem_d  = rem_sh - {1'b0, divisor};
    rem_n  = ge ? rem_d[31:0] : rem_sh[31:0];
    quo_n  = {src_q[30:0], ge};
  end

  // Packet FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= HDR0;
    else        state <= state_n;
  end

  // Next-state and response handshake.
  always_comb begin
    state_n       = state;
    tx_bus.tvalid = 1'b0;
    tx_bus.tdata  = rsh[31:24];
    unique case (state)
      HDR0: if (rx_ok) state_n = HDR1;
      HDR1: if (rx_ok) state_n = LENL;
      LENL: if (rx_ok) state_n = LENH;
      LENH: if (rx_ok) state_n = (len_full <= 16'd4) ? EXEC : PAY;
      PAY:  if (rx_ok && cnt_n == plen) state_n = EXEC;
      EXEC: begin
        if (is_add || is_mul)    state_n = RESP;
        else if (!is_div)        state_n = HDR0;
        else if (div_cnt == 5'd31) state_n = RESP;
      end
      RESP: begin
        tx_bus.tvalid = tx_bus.tready;
        if (tx_bus.tready && idx == 2'd3) state_n = HDR0;
      end
      default: state_n = HDR0;
    endcase
  end

  // Header capture, operand folding, divide and response byte index.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      op       <= '0;
      len_lo   <= '0;
      plen     <= '0;
      cnt      <= '0;
      word     <= '0;
      acc      <= '0;
      dividend <= '0;
      divisor  <= '0;
      nwords   <= '0;
      div_cnt  <= '0;
      quo      <= '0;
      rem      <= '0;
      result   <= '0;
      idx      <= '0;
    end else begin
      unique case (state)
        HDR0: if (rx_ok) op <= rx_b;
        LENL: if (rx_ok) len_lo <= rx_b;
        LENH: if (rx_ok) begin
          plen     <= (len_full <= 16'd4) ? 16'd0 : len_full - 16'd4;
          cnt      <= '0;
          word     <= '0;
          acc      <= is_mul ? 32'd1 : 32'd0;
          dividend <= '0;
          divisor  <= '0;
          nwords   <= '0;
          div_cnt  <= '0;
        end
        PAY: if (rx_ok) begin
          cnt  <= cnt_n;
          word <= word_n;
          if (cnt_n[1:0] == 2'b00) begin
            if (is_add) acc <= acc + word_n;
            if (is_mul) acc <= acc * word_n;
            if (is_div) begin
              if (nwords == 2'd0) dividend <= word_n;
              if (nwords == 2'd1) divisor  <= word_n;
              if (nwords != 2'd2) nwords   <= nwords + 2'd1;
            end
          end
        end
        EXEC: begin
          idx <= '0;
          if (is_add || is_mul) result <= acc;
          if (is_div) begin
            quo     <= quo_n;
            rem     <= rem_n;
            div_cnt <= div_cnt + 5'd1;
            if (div_cnt == 5'd31)
              result <= (nwords != 2'd2 || divisor == '0) ? '1 : quo_n;
          end
        end
        RESP: if (tx_bus.tready) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_top.sv
// Bench for uart_alu_top: serial host driver, line monitor, reference model.
// Uses a fast baud (8 clocks per bit) to keep runs short.
module tb_uart_alu_top;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 125000;
  localparam int BITC   = 8;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic rx_i = 1'b1;
  logic tx_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_q[$];
  logic [31:0] wq[$];

  uart_alu_if mon_bus ();

  always #5 clk = ~clk;

  uart_alu_top #(
    .datawidth_p (8),
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .tx_o  (tx_o)
  );

  // Host-side receiver of the DUT's serial output.
  initial begin
    logic [7:0] b;
    mon_bus.tvalid = 1'b0;
    mon_bus.tdata  = '0;
    mon_bus.tready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_i && tx_o === 1'b0) begin
        repeat (BITC / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (BITC) @(negedge clk);
        if (tx_o === 1'b1) begin
          mon_bus.tdata  = b;
          mon_bus.tvalid = 1'b1;
          @(negedge clk);
          mon_bus.tvalid = 1'b0;
        end
      end
    end
  end

  always @(posedge clk)
    if (mon_bus.tvalid) rx_q.push_back(mon_bus.tdata);

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BITC) @(negedge clk);
    end
    rx_i = !bad_stop;
    repeat (BITC) @(negedge clk);
    rx_i = 1'b1;
    repeat (BITC) @(negedge clk);
  endtask

  function automatic void model(input logic [7:0] op,
                                output bit has,
                                output logic [31:0] v);
    logic [63:0] a;
    has = 1'b1;
    v = '0;
    case (op)
      8'h10: begin
        a = 0;
        foreach (wq[i]) a = a + wq[i];
        v = a[31:0];
      end
      8'h11: begin
        a = 1;
        foreach (wq[i]) a = a * wq[i];
        v = a[31:0];
      end
      8'h12: begin
        if (wq.size() < 2 || wq[1] == 0) v = 32'hFFFF_FFFF;
        else v = wq[0] / wq[1];
      end
      default: has = 1'b0;
    endcase
  endfunction

  task automatic send_pkt(input logic [7:0] op, input int trail,
                          input int len_ovr);
    logic [15:0] len;
    logic [31:0] w;
    len = (len_ovr >= 0) ? 16'(len_ovr) : 16'(4 + 4 * wq.size() + trail);
    send_byte(op, 1'b0);
    send_byte(8'($urandom), 1'b0);
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
    if (len_ovr < 0) begin
      foreach (wq[i]) begin
        w = wq[i];
        send_byte(w[31:24], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8], 1'b0);
        send_byte(w[7:0], 1'b0);
      end
      repeat (trail) send_byte(8'($urandom), 1'b0);
    end
  endtask

  task automatic xact(input string nm, input logic [7:0] op,
                      input int trail, input int len_ovr);
    bit has;
    logic [31:0] exp, got;
    int t;
    send_pkt(op, trail, len_ovr);
    model(op, has, exp);
    checks++;
    if (has) begin
      t = 0;
      while (rx_q.size() < 4 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (rx_q.size() < 4) begin
        errors++;
        $display("FAIL %s: got %0d response bytes, need 4 (%h)",
                 nm, rx_q.size(), exp);
      end else begin
        got = {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
        if (got !== exp) begin
          errors++;
          $display("FAIL %s: response %h, expected %h", nm, got, exp);
        end
      end
    end else begin
      repeat (400) @(negedge clk);
      if (rx_q.size() != 0) begin
        errors++;
        $display("FAIL %s: %0d response bytes, expected none",
                 nm, rx_q.size());
      end
    end
    rx_q.delete();
  endtask

  task automatic test_reset();
    bit low_seen;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: tx_o=%b during reset, expected 1", tx_o);
    end
    rst_i = 1'b1;
    low_seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1) low_seen = 1'b1;
    end
    checks++;
    if (low_seen) begin
      errors++;
      $display("FAIL reset_idle: tx_o went low=1, expected stay high=0");
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL reset_nobytes: %0d bytes, expected 0", rx_q.size());
    end
  endtask

  task automatic test_add();
    wq = '{32'h1, 32'h2};
    xact("add", 8'h10, 0, -1);
    wq = '{32'hFFFF_FFFF, 32'h2};
    xact("add_wrap", 8'h10, 0, -1);
  endtask

  task automatic test_mul();
    wq = '{32'h3, 32'h4, 32'h0001_0000};
    xact("mul", 8'h11, 0, -1);
  endtask

  task automatic test_div();
    wq = '{32'd100, 32'd7};
    xact("div", 8'h12, 0, -1);
    wq = '{32'd100, 32'd0};
    xact("div_zero", 8'h12, 0, -1);
    wq = '{32'd55};
    xact("div_one_op", 8'h12, 0, -1);
    wq = '{32'hFFFF_FFFF, 32'd3, 32'd0};
    xact("div_extra", 8'h12, 0, -1);
  endtask

  task automatic test_unknown();
    wq = '{32'h1234_5678};
    xact("unknown_op", 8'h55, 0, -1);
    wq = '{32'd5, 32'd6};
    xact("after_unknown", 8'h10, 0, -1);
  endtask

  task automatic test_boundaries();
    wq.delete();
    xact("len2_add", 8'h10, 0, 2);
    xact("mul_noops", 8'h11, 0, 4);
    xact("div_len0", 8'h12, 0, 0);
    wq = '{32'h0000_0100, 32'h0000_0023};
    xact("add_trail3", 8'h10, 3, -1);
  endtask

  task automatic test_frame_error();
    send_byte(8'h10, 1'b1);
    repeat (40) @(negedge clk);
    wq = '{32'd9, 32'd10};
    xact("after_frame_err", 8'h10, 0, -1);
  endtask

  task automatic test_reset_mid();
    int t;
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    wq = '{32'd5, 32'd6};
    xact("reset_mid_pkt", 8'h10, 0, -1);

    wq = '{32'd7, 32'd8};
    send_pkt(8'h10, 0, -1);
    t = 0;
    while (tx_o !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL resp_start: tx_o=%b, expected 0 (start bit)", tx_o);
    end
    repeat (20) @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_resp: tx_o=%b, expected 1", tx_o);
    end
    rst_i = 1'b1;
    repeat (200) @(negedge clk);
    rx_q.delete();
    repeat (400) @(negedge clk);
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL resp_discarded: %0d bytes, expected 0", rx_q.size());
    end
    wq = '{32'd20, 32'd22};
    xact("after_resp_reset", 8'h10, 0, -1);
  endtask

  task automatic test_random();
    logic [7:0] op;
    int r, n, tr;
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 3);
      op = (r == 0) ? 8'h10 : (r == 1) ? 8'h11 :
           (r == 2) ? 8'h12 : 8'h80 | 8'($urandom_range(0, 127));
      n = $urandom_range(0, 3);
      tr = $urandom_range(0, 3);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      if (op == 8'h12 && n >= 2 && $urandom_range(0, 1) == 1)
        wq[1] = 32'($urandom_range(0, 20));
      xact($sformatf("random%0d_op%h", k, op), op, tr, -1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_unknown();
    test_boundaries();
    test_frame_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
